imem_loader: RTL and testbench

- Writer side of the instruction memory: receives a program image as a byte stream and writes it word by word into a writable instruction memory.
- The instruction memory's read port is still indexed by pc[31:2].
- Holds the CPU (cpu_hold) for the whole load, so fetch never sees a partial image.
- Sits between a byte source (UART receiver or testbench) and the instruction memory write port.

---
 rtl/imem_loader.sv | 145 ++++++++++++++
 tb/tb_imem_loader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream program loader: writes a counted, MSB-first word image into instruction memory
// while holding the CPU. Optional trailing XOR checksum byte under IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int unsigned DEPTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        overflow,
    output logic        chk_err
);

    typedef enum logic [2:0] {StIdle, StHdrHi, StHdrLo, StData, StChk, StFin} state_e;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_e AfterData = StChk;
`else
    localparam state_e AfterData = StFin;
`endif

    state_e      state_q, state_d;
    logic [15:0] cnt_q;
    logic [15:0] idx_q;
    logic [1:0]  byte_q;
    logic [23:0] asm_q;
    logic [15:0] hdr_n;
    logic        xfer;
    logic        word_done;
    logic        last_word;

    assign xfer      = in_valid && in_ready;
    assign hdr_n     = {cnt_q[15:8], in_data};
    assign word_done = (state_q == StData) && xfer && (byte_q == 2'd3);
    assign last_word = (idx_q == cnt_q - 16'd1);
    assign cpu_hold  = (state_q != StIdle);

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) state_d = StHdrHi;
            end
            StHdrHi: begin
                in_ready = 1'b1;
                if (in_valid) state_d = StHdrLo;
            end
            StHdrLo: begin
                in_ready = 1'b1;
                if (in_valid) state_d = (hdr_n == 16'd0) ? AfterData : StData;
            end
            StData: begin
                in_ready = 1'b1;
                if (word_done && last_word) state_d = AfterData;
            end
            StChk: begin
                in_ready = 1'b1;
                if (in_valid) state_d = StFin;
            end
            StFin: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            idx_q     <= '0;
            byte_q    <= '0;
            asm_q     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= '0;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state_q <= state_d;
            mem_we  <= 1'b0;
            done    <= (state_q == StFin);
            if (state_q == StIdle && start) begin
                overflow <= 1'b0;
                idx_q    <= '0;
                byte_q   <= '0;
            end
            if (xfer) begin
                case (state_q)
                    StHdrHi: cnt_q[15:8] <= in_data;
                    StHdrLo: begin
                        cnt_q[7:0] <= in_data;
                        if ({16'd0, hdr_n} > DEPTH) overflow <= 1'b1;
                    end
                    StData: begin
                        asm_q  <= {asm_q[15:0], in_data};
                        byte_q <= byte_q + 2'd1;
                        if (byte_q == 2'd3) begin
                            // Words beyond DEPTH are consumed but never written.
                            if ({16'd0, idx_q} < DEPTH) begin
                                mem_we    <= 1'b1;
                                mem_wdata <= {asm_q, in_data};
                                mem_addr  <= BASE_ADDR + {14'd0, idx_q, 2'b00};
                            end
                            idx_q <= idx_q + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] sum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            chk_err <= 1'b0;
        end else if (state_q == StIdle && start) begin
            sum_q   <= '0;
            chk_err <= 1'b0;
        end else if (xfer) begin
            if (state_q == StChk) begin
                if (in_data != sum_q) chk_err <= 1'b1;
            end else begin
                sum_q <= sum_q ^ in_data;
            end
        end
    end
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal load, stalls, empty image, overflow, mid-load reset
// and (with IMEM_LOADER_CHECKSUM_EN) checksum pass/fail.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        overflow;
    logic        chk_err;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    logic [31:0] img[0:31];
    logic [7:0]  tb_sum;

    imem_loader #(.DEPTH(16), .BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .done(done), .overflow(overflow), .chk_err(chk_err)
    );

    always #5 clk = ~clk;

    // Sample outputs half a cycle after the active edge.
    always @(negedge clk) begin
        if (mem_we) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
        end
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        in_valid = 1'b1;
        in_data  = b;
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        tb_sum   = tb_sum ^ b;
    endtask

    task automatic do_start();
        wa.delete();
        wd.delete();
        tb_sum = 8'h00;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("hold_on_start", 32'(cpu_hold), 32'd1);
    endtask

    // Sends header, n words from img (optional 5-cycle stall in word stall_w) and checksum byte.
    task automatic load_image(input int n, input int stall_w, input logic bad_chk);
        logic [31:0] w;
        send_byte(8'(n >> 8));
        send_byte(8'(n));
        check("overflow_hdr", 32'(overflow), (n > 16) ? 32'd1 : 32'd0);
        for (int i = 0; i < n; i++) begin
            w = img[i];
            for (int b = 0; b < 4; b++) begin
                send_byte(w[31 - 8*b -: 8]);
                if (i == stall_w && b == 1) begin
                    for (int s = 0; s < 5; s++) begin
                        @(negedge clk);
                        check("stall_no_we", 32'(mem_we), 32'd0);
                    end
                end
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(bad_chk ? ~tb_sum : tb_sum);
`else
        if (bad_chk) check("bad_chk_unsupported", 32'd0, 32'd0 + 32'(bad_chk));
`endif
    endtask

    task automatic finish_checks(input logic exp_we, input int exp_done);
`ifndef IMEM_LOADER_CHECKSUM_EN
        check("last_we", 32'(mem_we), 32'(exp_we));
`endif
        check("done_early", 32'(done), 32'd0);
        @(negedge clk);
        check("done", 32'(done), 32'd1);
        check("hold_release", 32'(cpu_hold), 32'd0);
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
        check("done_count", 32'(done_cnt), 32'(exp_done));
    endtask

    task automatic verify_writes(input int n);
        int m;
        m = (n > 16) ? 16 : n;
        check("write_count", 32'(wa.size()), 32'(m));
        for (int i = 0; i < m && i < wa.size(); i++) begin
            check("write_addr", wa[i], 32'(i * 4));
            check("write_data", wd[i], img[i]);
        end
    endtask

    task automatic set_prog();
        img[0] = 32'h0022_1820;
        img[1] = 32'hAC01_0000;
        img[2] = 32'h8C24_0000;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; tb_sum = 8'h00;
        set_prog();
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_chk_err", 32'(chk_err), 32'd0);
        rst = 1'b0;

        // Three-word program, no stalls.
        do_start();
        load_image(3, -1, 1'b0);
        finish_checks(1'b1, 1);
        verify_writes(3);

        // Same program with a stall inside word 1.
        do_start();
        load_image(3, 1, 1'b0);
        finish_checks(1'b1, 2);
        verify_writes(3);

        // Empty image.
        do_start();
        load_image(0, -1, 1'b0);
        finish_checks(1'b0, 3);
        check("n0_overflow", 32'(overflow), 32'd0);
        verify_writes(0);

        // 18 words into a 16-word memory.
        for (int i = 0; i < 18; i++) img[i] = 32'hA5A0_0000 + 32'(i * 32'h0001_0203);
        do_start();
        load_image(18, -1, 1'b0);
        finish_checks(1'b0, 4);
        verify_writes(18);
        check("ovf_last_addr", wa[wa.size() - 1], 32'h0000_003C);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Reset after two bytes of word 1.
        set_prog();
        do_start();
        check("restart_clears_ovf", 32'(overflow), 32'd0);
        send_byte(8'h00);
        send_byte(8'h02);
        for (int b = 0; b < 4; b++) send_byte(img[0][31 - 8*b -: 8]);
        send_byte(img[1][31:24]);
        send_byte(img[1][23:16]);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_mem_we", 32'(mem_we), 32'd0);
        check("mid_rst_mem_addr", mem_addr, 32'd0);
        check("mid_rst_mem_wdata", mem_wdata, 32'd0);
        check("mid_rst_cpu_hold", 32'(cpu_hold), 32'd0);
        repeat (4) @(negedge clk);
        check("mid_rst_writes", 32'(wa.size()), 32'd1);
        check("mid_rst_word0", wd[0], img[0]);
        check("mid_rst_no_done", 32'(done_cnt), 32'd4);
        do_start();
        load_image(3, -1, 1'b0);
        finish_checks(1'b1, 5);
        verify_writes(3);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // XOR of 00 01 10 21 00 01 is 0x31.
        img[0] = 32'h1021_0001;
        do_start();
        load_image(1, -1, 1'b0);
        check("chk_sum_model", 32'(tb_sum), 32'h0000_0031);
        finish_checks(1'b1, 6);
        check("chk_ok", 32'(chk_err), 32'd0);
        do_start();
        load_image(1, -1, 1'b1);
        finish_checks(1'b1, 7);
        check("chk_bad", 32'(chk_err), 32'd1);
        verify_writes(1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
